// File: rtl/col_frame_loader_pkg.sv
// Shared definitions for the column frame loader: header field positions
// and the sequencing states.
package col_frame_loader_pkg;

  localparam int HDR_FLAG_BIT = 31;
  localparam int COL_MSB      = 15;
  localparam int COL_LSB      = 8;
  localparam int IDX_MSB      = 4;
  localparam int IDX_LSB      = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/col_frame_loader.sv
// Column-base configuration loader. Collects one data word per row after a
// header, then fires a single FrameStrobe line while FrameData is stable.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a header; non-header words are consumed and dropped
// LOAD   | consuming NumRows data words, written only when the column matches
// STROBE | one-hot FrameStrobe for the latched frame index
// HOLD   | strobe released, FrameData still held
// DONE   | frame_done pulse, frame_err if the frame index was out of range
module col_frame_loader
  import col_frame_loader_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 16,
  parameter int ColumnIndex     = 0
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  input  logic [31:0]                          in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData_O,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe_O,
  output logic                                 frame_done,
  output logic                                 frame_err
);

  localparam int               ROW_W    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [7:0]       COL_ID   = 8'(ColumnIndex);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumRows - 1);

  state_t                                   state_q;
  state_t                                   state_d;
  logic [ROW_W-1:0]                         row_q;
  logic [4:0]                               idx_q;
  logic                                     match_q;
  logic                                     bad_q;
  logic [NumRows-1:0][FrameBitsPerRow-1:0]  rows_q;
  logic                                     hdr_take;
  logic                                     word_take;

  // State register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, handshake and strobe/status outputs. in_ready is gated by
  // resetn so nothing is offered upstream while the loader is held in reset.
  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    FrameStrobe_O = '0;
    frame_done    = 1'b0;
    frame_err     = 1'b0;
    hdr_take      = 1'b0;
    word_take     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = resetn;
        if (in_valid && resetn && in_data[HDR_FLAG_BIT]) begin
          hdr_take = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        in_ready = resetn;
        if (in_valid && resetn) begin
          word_take = 1'b1;
          if (row_q == LAST_ROW) state_d = (match_q && !bad_q) ? STROBE : DONE;
        end
      end
      STROBE: begin
        for (int i = 0; i < MaxFramesPerCol; i++) FrameStrobe_O[i] = (int'(idx_q) == i);
        state_d = HOLD;
      end
      HOLD: state_d = DONE;
      DONE: begin
        frame_done = 1'b1;
        frame_err  = bad_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Header capture: only the column match and range check are kept.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      idx_q   <= '0;
      match_q <= 1'b0;
      bad_q   <= 1'b0;
    end else if (hdr_take) begin
      idx_q   <= in_data[IDX_MSB:IDX_LSB];
      match_q <= (in_data[COL_MSB:COL_LSB] == COL_ID);
      bad_q   <= (int'(in_data[IDX_MSB:IDX_LSB]) >= MaxFramesPerCol);
    end
  end

  // Row counter; holds while in_valid is low.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)        row_q <= '0;
    else if (hdr_take)  row_q <= '0;
    else if (word_take) row_q <= row_q + ROW_W'(1);
  end

  // Row-parallel frame register, written by index for matching columns only.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)                   rows_q        <= '0;
    else if (word_take && match_q) rows_q[row_q] <= in_data;
  end

  assign FrameData_O = rows_q;

endmodule

// File: tb/tb_col_frame_loader.sv
// Randomized bench for col_frame_loader with a frame-level reference model.
module tb_col_frame_loader;

  localparam int NR = 16;
  localparam int NF = 20;
  localparam int W  = NR * 32;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  FrameData_O;
  logic [NF-1:0] FrameStrobe_O;
  logic          frame_done;
  logic          frame_err;

  col_frame_loader #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(NF),
    .NumRows(NR),
    .ColumnIndex(0)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .FrameData_O(FrameData_O),
    .FrameStrobe_O(FrameStrobe_O),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what each row should hold.
  logic [31:0] exp_rows[NR];
  logic [31:0] frame_words[NR];

  function automatic logic [W-1:0] exp_vec();
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r*32 +: 32] = exp_rows[r];
    return v;
  endfunction

  // Observers: count strobe pulses, done/err pulses and any multi-hot strobe.
  int  strobe_cnt = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  bit  multi = 1'b0;
  always @(negedge CLK) begin
    if (FrameStrobe_O != '0) begin
      strobe_cnt++;
      if ($countones(FrameStrobe_O) > 1) multi = 1'b1;
    end
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  // Offer one word after a random idle gap; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] w, input int max_gap);
    int  gap;
    bit  acc;
    bit  ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    ok  = 1'b0;
    in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      acc = in_ready;
      @(posedge CLK);
      #1;
      if (acc) ok = 1'b1;
      else @(negedge CLK);
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Drives a header plus NR words from frame_words and checks the whole transaction.
  task automatic run_frame(input logic [31:0] hdr, input int max_gap, input string tag);
    logic [7:0]    col;
    logic [4:0]    idx;
    bit            match;
    bit            bad;
    bit            good;
    logic [NF-1:0] es;
    int            s0, d0, e0;
    col   = hdr[15:8];
    idx   = hdr[4:0];
    match = (col == 8'd0);
    bad   = (int'(idx) >= NF);
    good  = match && !bad;
    es    = '0;
    if (good) es[idx] = 1'b1;
    s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;

    send_word(hdr, max_gap);
    for (int k = 0; k < NR; k++) begin
      send_word(frame_words[k], max_gap);
      if (match) exp_rows[k] = frame_words[k];
    end
    in_valid = 1'b0;

    if (good) begin
      @(negedge CLK);
      check({tag, "_strobe"}, FrameStrobe_O, es);
      check({tag, "_rdy1"}, in_ready, 0);
      check({tag, "_done_early"}, frame_done, 0);
      @(negedge CLK);
      check({tag, "_hold_strobe"}, FrameStrobe_O, 0);
      check({tag, "_rdy2"}, in_ready, 0);
      @(negedge CLK);
      check({tag, "_done"}, frame_done, 1);
      check({tag, "_err"}, frame_err, 0);
      check({tag, "_rdy3"}, in_ready, 0);
      @(negedge CLK);
      check({tag, "_rdy_back"}, in_ready, 1);
    end else begin
      @(negedge CLK);
      check({tag, "_done"}, frame_done, 1);
      check({tag, "_err"}, frame_err, bad);
      check({tag, "_nostrobe"}, FrameStrobe_O, 0);
      check({tag, "_rdy1"}, in_ready, 0);
      @(negedge CLK);
      check({tag, "_rdy_back"}, in_ready, 1);
    end
    check({tag, "_data"}, FrameData_O, exp_vec());
    check({tag, "_strobe_cnt"}, strobe_cnt - s0, good ? 1 : 0);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_err_cnt"}, err_cnt - e0, bad ? 1 : 0);
    check({tag, "_onehot"}, multi, 0);
  endtask

  initial begin
    int          s0, d0;
    logic [31:0] hdr;

    for (int r = 0; r < NR; r++) exp_rows[r] = '0;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_ready", in_ready, 0);
    check("rst_data", FrameData_O, 0);
    check("rst_strobe", FrameStrobe_O, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    resetn = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", in_ready, 1);

    // Basic frame 3 in column 0.
    for (int k = 0; k < NR; k++) frame_words[k] = 32'h1000_0000 + 32'(k);
    run_frame(32'h8000_0003, 0, "basic");

    // Other column: words consumed, nothing changes.
    for (int k = 0; k < NR; k++) frame_words[k] = $urandom;
    run_frame(32'h8000_0105, 1, "mismatch");

    // Out-of-range index: data loads, no strobe, error pulse.
    for (int k = 0; k < NR; k++) frame_words[k] = $urandom;
    run_frame(32'h8000_0014, 1, "badidx");

    // Stalled delivery of words that look like headers.
    for (int k = 0; k < NR; k++) frame_words[k] = $urandom | 32'h8000_0000;
    run_frame(32'h8000_000A, 4, "stall");

    // Non-header words in IDLE are dropped.
    s0 = strobe_cnt; d0 = done_cnt;
    send_word(32'h7FFF_FFFF, 0);
    send_word(32'h0000_0000, 0);
    in_valid = 1'b0;
    @(negedge CLK);
    check("idle_ready", in_ready, 1);
    check("idle_data", FrameData_O, exp_vec());
    check("idle_done", done_cnt - d0, 0);
    check("idle_strobe", strobe_cnt - s0, 0);
    for (int k = 0; k < NR; k++) frame_words[k] = $urandom;
    run_frame(32'h8000_0000, 0, "after_idle");

    // Random headers: ignored bits, random column and index.
    for (int n = 0; n < 8; n++) begin
      hdr = $urandom | 32'h8000_0000;
      if ($urandom_range(1, 0) == 1) hdr[15:8] = 8'h00;
      for (int k = 0; k < NR; k++) frame_words[k] = $urandom;
      run_frame(hdr, 2, "rand");
    end

    // Reset in the middle of a frame.
    s0 = strobe_cnt;
    send_word(32'h8000_0002, 0);
    for (int k = 0; k < 8; k++) send_word(32'hCAFE_0000 + 32'(k), 0);
    in_valid = 1'b0;
    @(negedge CLK);
    resetn = 1'b0;
    #1;
    for (int r = 0; r < NR; r++) exp_rows[r] = '0;
    check("midrst_ready", in_ready, 0);
    check("midrst_data", FrameData_O, 0);
    check("midrst_strobe", FrameStrobe_O, 0);
    check("midrst_done", frame_done, 0);
    @(negedge CLK);
    resetn = 1'b1;
    repeat (3) @(negedge CLK);
    check("midrst_nostrobe", strobe_cnt - s0, 0);
    check("midrst_idle_ready", in_ready, 1);
    for (int k = 0; k < NR; k++) frame_words[k] = $urandom;
    run_frame(32'h8000_0013, 0, "frame19");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/col_frame_loader.md
# col_frame_loader

Column-base configuration loader that drives the FrameData/FrameStrobe buses feeding the bottom of one fabric column, upstream of every tile's FrameData/FrameStrobe daisy-chain buffers up to the N terminator. It accepts a stream of 32-bit configuration words through a valid/ready handshake and decodes a header word. It collects one data word per row into a row-parallel frame register, then pulses exactly one FrameStrobe line for one cycle while FrameData is held stable.

## Interface
Parameters:
- FrameBitsPerRow, 32: width of one row's frame data word; must be 32.
- MaxFramesPerCol, 20: number of FrameStrobe lines.
- NumRows, 16: tiles in the column; one data word per row per frame.
- ColumnIndex, 0: this loader's column address, 8 bits.

Ports:
- CLK, input, 1: configuration clock; all state on rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- in_data, input, 32: configuration word.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: loader accepts a word; transfer occurs when in_valid and in_ready are both high on a rising edge.
- FrameData_O, output, NumRows*FrameBitsPerRow: row r occupies bits [r*32+31 : r*32].
- FrameStrobe_O, output, MaxFramesPerCol: one-hot write strobe.
- frame_done, output, 1: one-cycle pulse when a frame transaction ends, whether or not a strobe was issued.
- frame_err, output, 1: one-cycle pulse when a transaction ends whose header frame index is ≥ MaxFramesPerCol.

## Operation
Header word format:
- bit 31 = 1 marks a header.
- bits [15:8] hold the column.
- bits [4:0] hold the frame index.
- All other bits are ignored.

State machine:
- IDLE
  - in_ready=1.
  - A word with bit 31=0 is accepted and dropped.
  - A header is accepted; the loader latches the column and frame index, clears the row counter, sets match = (column==ColumnIndex), sets bad = (index ≥ MaxFramesPerCol), and goes to LOAD.
- LOAD
  - in_ready=1.
  - Every accepted word is a data word, including words with bit 31 set.
  - Word k, k = 0..NumRows-1, is written only when match is set; it goes into row k of FrameData_O on the acceptance edge.
  - On a mismatch, words are consumed and FrameData_O is left unchanged.
  - After word NumRows-1: go to STROBE if match and not bad; otherwise go to DONE.
- STROBE
  - in_ready=0.
  - FrameStrobe_O[index]=1 for exactly one cycle; go to HOLD.
- HOLD
  - in_ready=0.
  - FrameStrobe_O=0; FrameData_O is held. Go to DONE.
- DONE
  - in_ready=0.
  - frame_done=1, and frame_err=bad for this cycle. Go to IDLE.

Row counter width is $clog2(NumRows).

Output rules:
- FrameData_O changes only on accepted LOAD words with match set, or on reset.
- FrameStrobe_O is never multi-hot.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=1 while resetn is high after reset release, and 0 while resetn is low.
  - FrameData_O=0, FrameStrobe_O=0, frame_done=0, frame_err=0.
- Latency, with the last data word accepted at edge t:
  - FrameStrobe_O high for cycle t..t+1.
  - HOLD follows.
  - DONE pulses during t+2..t+3.
  - in_ready returns high at t+3.
- Throughput: NumRows+1 accepted words plus 3 cycles per frame.
- Stalls: in_valid low in LOAD stalls without timeout; the row counter holds.
- Reset mid-transaction:
  - Aborts immediately; no strobe is issued.
  - FrameData_O is cleared; the partial frame is discarded.
- Bad index with matching column: data is still loaded into FrameData_O, but no strobe is issued; frame_err=1 in DONE.
- in_valid while in_ready=0 is not consumed; the upstream must hold the word.

## Structure
- Package col_frame_loader_pkg holds:
  - header bit positions: HDR_FLAG_BIT=31, COL_MSB/LSB=15/8, IDX_MSB/LSB=4/0;
  - state enum {IDLE, LOAD, STROBE, HOLD, DONE}.
- Single module; no sub-module. The row register is an indexed write, not a shifter.

## Test plan
- Reset, then header 0x8000_0003 (col 0, frame 3) and 16 words 0x1000_0000+k:
  - row k = 0x1000_0000+k;
  - FrameStrobe_O=0x00008 for one cycle one cycle after the last word;
  - frame_done one cycle after HOLD; frame_err=0.
- Header 0x8000_0105 (col 1) into a ColumnIndex=0 loader:
  - 16 words are consumed;
  - FrameData_O is unchanged, no strobe;
  - frame_done=1, frame_err=0.
- Header 0x8000_0014 (index 20):
  - data is loaded, no strobe;
  - frame_err=1 coincident with frame_done.
- Header, then in_valid toggled randomly across the 16 words, with data words having bit 31 set:
  - all rows are captured in order;
  - a single strobe is issued;
  - in_ready is low exactly 3 cycles after the last word.
- In IDLE, words 0x7FFF_FFFF and 0x0000_0000 are accepted with no state change; then a valid header proceeds normally.
- resetn pulsed low after word 7 of a frame:
  - all outputs are 0, no strobe;
  - the next full frame (frame 19) strobes bit 19 only.
